// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128/192/256 key expansion into a word buffer, round keys read by index (forward or inverse).
module aes_key_schedule #(
    parameter int MAX_NK   = 8,
    parameter bit SBOX_REG = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [32*MAX_NK-1:0]  key_in,
    output logic                  busy,
    output logic                  done,
    output logic                  keys_valid,
    output logic                  err,
    output logic [3:0]            num_rounds,
    input  logic                  rd_en,
    input  logic [3:0]            rd_round,
    input  logic                  rd_inv,
    output logic [127:0]          rd_key,
    output logic                  rd_valid
);
    localparam int DEPTH = 4*(MAX_NK+7);

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    // S-box computed as GF(2^8) inverse (x^254) followed by the affine map
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] s_box(input logic [7:0] a);
        logic [7:0] r, pw, ex, v;
        r  = 8'h01;
        pw = a;
        ex = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (ex[i]) r = gmul(r, pw);
            pw = gmul(pw, pw);
        end
        v = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return v;
    endfunction

    state_t state, next;
    logic [31:0] mem [DEPTH];
    logic [3:0]  nk, nk_new, nr_new, mcnt, e;
    logic [5:0]  cnt, last;
    logic [7:0]  rcon;
    logic        phase, wr, last_wr, load, rd_ok;
    logic [31:0] prev, old, sub_in, sub, temp, temp_q, wr_word;

    assign busy    = state == EXPAND;
    assign load    = state != EXPAND && start && key_len != 2'b11;
    assign nk      = num_rounds - 4'd6;
    assign nk_new  = {1'b0, key_len, 1'b0} + 4'd4;
    assign nr_new  = nk_new + 4'd6;
    assign last    = {num_rounds, 2'b00} + 6'd3;
    assign prev    = mem[cnt - 6'd1];
    assign old     = mem[cnt - {2'b00, nk}];
    assign sub_in  = mcnt == 4'd0 ? {prev[23:0], prev[31:24]} : prev;
    assign wr      = state == EXPAND && (!SBOX_REG || phase);
    assign last_wr = wr && cnt == last;
    assign wr_word = old ^ (SBOX_REG ? temp_q : temp);
    assign e       = rd_inv ? num_rounds - rd_round : rd_round;
    assign rd_ok   = rd_en && keys_valid && rd_round <= num_rounds;

    for (genvar g = 0; g < 4; g++) begin : g_sub
        assign sub[8*g +: 8] = s_box(sub_in[8*g +: 8]);
    end

    always_comb begin
        temp = mcnt == 4'd0 ? sub ^ {rcon, 24'h0} : (nk == 4'd8 && mcnt == 4'd4) ? sub : prev;
    end

    always_comb begin
        next = state;
        if (load) next = EXPAND;
        else if (last_wr) next = READY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            for (int j = 0; j < MAX_NK; j++)
                if (j < int'(nk_new)) mem[j] <= key_in[32*(MAX_NK-j)-1 -: 32];
        end else if (wr) begin
            mem[cnt] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done       <= 1'b0;
            err        <= 1'b0;
            keys_valid <= 1'b0;
            num_rounds <= 4'd0;
            cnt        <= 6'd0;
            mcnt       <= 4'd0;
            rcon       <= 8'h01;
            phase      <= 1'b0;
            temp_q     <= 32'h0;
            rd_valid   <= 1'b0;
            rd_key     <= 128'h0;
        end else begin
            err      <= state != EXPAND && start && key_len == 2'b11;
            done     <= last_wr;
            rd_valid <= rd_ok;
            if (rd_ok) rd_key <= {mem[{e, 2'b00}], mem[{e, 2'b01}], mem[{e, 2'b10}], mem[{e, 2'b11}]};
            if (load) begin
                num_rounds <= nr_new;
                cnt        <= {2'b00, nk_new};
                mcnt       <= 4'd0;
                rcon       <= 8'h01;
                phase      <= 1'b0;
                keys_valid <= 1'b0;
            end else if (state == EXPAND) begin
                phase  <= SBOX_REG ? !phase : 1'b0;
                temp_q <= temp;
                if (wr) begin
                    cnt  <= cnt + 6'd1;
                    mcnt <= mcnt == nk - 4'd1 ? 4'd0 : mcnt + 4'd1;
                    if (mcnt == 4'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    if (last_wr) keys_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: directed known-answer checks of expansion latency, round-key reads, errors and reset abort.
module tb_aes_key_schedule;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'b00;
    logic [255:0] key_in = '0;
    logic         busy, done, keys_valid, err, rd_valid;
    logic [3:0]   num_rounds;
    logic         rd_en = 1'b0;
    logic [3:0]   rd_round = 4'd0;
    logic         rd_inv = 1'b0;
    logic [127:0] rd_key;
    int           checks = 0;
    int           fails = 0;
    int           n;

    localparam logic [127:0] K128A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K128B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    aes_key_schedule dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key_in(key_in),
        .busy(busy), .done(done), .keys_valid(keys_valid), .err(err), .num_rounds(num_rounds),
        .rd_en(rd_en), .rd_round(rd_round), .rd_inv(rd_inv), .rd_key(rd_key), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [1:0] len, input logic [255:0] key, output int cycles);
        key_in  = key;
        key_len = len;
        start   = 1'b1;
        tick();
        start  = 1'b0;
        cycles = 0;
        while (!done && cycles < 300) begin
            tick();
            cycles++;
        end
    endtask

    task automatic rd(input logic [3:0] r, input logic inv);
        rd_round = r;
        rd_inv   = inv;
        rd_en    = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_kv", 128'(keys_valid), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        chk("rst_nr", 128'(num_rounds), 128'd0);
        chk("rst_rdv", 128'(rd_valid), 128'd0);
        chk("rst_key", rd_key, 128'd0);
        rst_n = 1'b1;
        tick();
        rd(4'd0, 1'b0);
        chk("rd_no_keys", 128'(rd_valid), 128'd0);

        run(2'b00, {K128A, 128'h0}, n);
        chk("a128_cycles", 128'(n), 128'd40);
        chk("a128_kv", 128'(keys_valid), 128'd1);
        chk("a128_busy", 128'(busy), 128'd0);
        chk("a128_nr", 128'(num_rounds), 128'd10);
        tick();
        chk("a128_done_pulse", 128'(done), 128'd0);
        rd(4'd10, 1'b0);
        chk("a128_r10_valid", 128'(rd_valid), 128'd1);
        chk("a128_r10", rd_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        rd(4'd0, 1'b1);
        chk("a128_inv0", rd_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        rd(4'd1, 1'b0);
        chk("a128_r1", rd_key, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        tick();
        chk("rdv_idle", 128'(rd_valid), 128'd0);

        run(2'b00, {K128B, 128'h0}, n);
        chk("b128_cycles", 128'(n), 128'd40);
        rd(4'd10, 1'b0);
        chk("b128_r10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd(4'd0, 1'b0);
        chk("b128_r0", rd_key, K128B);
        rd(4'd1, 1'b0);
        chk("b128_r1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
        rd(4'd10, 1'b1);
        chk("b128_inv10", rd_key, K128B);

        run(2'b01, {K192, 64'h0}, n);
        chk("a192_cycles", 128'(n), 128'd46);
        chk("a192_nr", 128'(num_rounds), 128'd12);
        rd(4'd12, 1'b0);
        chk("a192_r12", rd_key, 128'ha4970a331a78dc09c418c271e3a41d5d);
        rd(4'd0, 1'b0);
        chk("a192_r0", rd_key, K128A);

        key_len = 2'b11;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("err_pulse", 128'(err), 128'd1);
        chk("err_kv", 128'(keys_valid), 128'd1);
        chk("err_busy", 128'(busy), 128'd0);
        tick();
        chk("err_once", 128'(err), 128'd0);
        rd(4'd12, 1'b0);
        chk("err_r12", rd_key, 128'ha4970a331a78dc09c418c271e3a41d5d);

        key_in  = K256;
        key_len = 2'b10;
        start   = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
            if (n == 5) begin
                rd_round = 4'd0;
                rd_inv   = 1'b0;
                rd_en    = 1'b1;
            end
            if (n == 6) begin
                chk("rd_during_expand", 128'(rd_valid), 128'd0);
                rd_en = 1'b0;
            end
            if (n == 10) begin
                key_len = 2'b00;
                start   = 1'b1;
            end
            if (n == 11) begin
                start = 1'b0;
                chk("start_mid_err", 128'(err), 128'd0);
            end
        end
        chk("a256_cycles", 128'(n), 128'd52);
        chk("a256_nr", 128'(num_rounds), 128'd14);
        rd(4'd14, 1'b0);
        chk("a256_r14", rd_key, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        rd(4'd15, 1'b0);
        chk("a256_r15_valid", 128'(rd_valid), 128'd0);
        chk("a256_r15_hold", rd_key, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        rd(4'd0, 1'b1);
        chk("a256_inv0", rd_key, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        rd(4'd1, 1'b0);
        chk("a256_r1", rd_key, 128'h101112131415161718191a1b1c1d1e1f);

        key_in  = K256;
        key_len = 2'b10;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("mid_busy", 128'(busy), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_kv", 128'(keys_valid), 128'd0);
        chk("abort_nr", 128'(num_rounds), 128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run(2'b00, {K128A, 128'h0}, n);
        chk("post_rst_cycles", 128'(n), 128'd40);
        rd(4'd10, 1'b0);
        chk("post_rst_r10", rd_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
